// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;
  localparam int DATA_W = 16;
  localparam int DIV_CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOADM,
    CALC,
    DONE
  } div_state_e;
endpackage

// File: rtl/div_datapath.sv
// A/Q/M registers, shift/subtract step and iteration counter.
module div_datapath
  import div_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int CW = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_q_i,
  input  logic         ld_m_i,
  input  logic         calc_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] a_d_o,
  output logic [W-1:0] q_d_o,
  output logic         eqz_o,
  output logic         m_is_zero_o
);
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_sh, q_sh;
  logic [W:0]    trial;

  always_comb begin
    a_sh  = {a_q[W-2:0], q_q[W-1]};
    q_sh  = {q_q[W-2:0], 1'b0};
    trial = {1'b0, a_sh} - {1'b0, m_q};
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      ld_q_i: begin
        q_d   = data_i;
        a_d   = '0;
        cnt_d = CW'(W);
      end
      ld_m_i: m_d = data_i;
      calc_i: begin
        // A negative trial means M did not fit: restore A
        if (!trial[W]) begin
          a_d = trial[W-1:0];
          q_d = {q_sh[W-1:1], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = q_sh;
        end
        cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o         = q_q;
  assign a_d_o       = a_d;
  assign q_d_o       = q_d;
  assign eqz_o       = (cnt_q == CW'(1));
  assign m_is_zero_o = (data_i == '0);
endmodule

// File: rtl/top_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// result {remainder, quotient} with a one-cycle done pulse.
module top_restoring_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int OUTPUT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    done,
  output logic                    busy,
  output logic                    div_by_zero
);
  div_state_e state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;
  logic dbz_q, dbz_d;
  logic ld_q, ld_m, calc;
  logic [DATA_WIDTH-1:0] q, a_d, q_d;
  logic eqz, m_is_zero;

  div_datapath #(
    .W  (DATA_WIDTH),
    .CW ($clog2(DATA_WIDTH + 1))
  ) u_dp (
    .clk         (clk),
    .rst         (clear),
    .ld_q_i      (ld_q),
    .ld_m_i      (ld_m),
    .calc_i      (calc),
    .data_i      (data_in),
    .q_o         (q),
    .a_d_o       (a_d),
    .q_d_o       (q_d),
    .eqz_o       (eqz),
    .m_is_zero_o (m_is_zero)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      dout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOADM;
      LOADM:   state_d = m_is_zero ? DONE : CALC;
      CALC:    if (eqz) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result is captured on DONE entry so it lines up with the done pulse
  always_comb begin
    ld_q   = (state_q == IDLE) && start;
    ld_m   = (state_q == LOADM);
    calc   = (state_q == CALC);
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    dout_d = dout_q;
    dbz_d  = dbz_q;
    if (ld_m && m_is_zero) begin
      dout_d = {q, DIV_ZERO_Q};
      dbz_d  = 1'b1;
    end else if (calc && eqz) begin
      dout_d = {a_d, q_d};
      dbz_d  = 1'b0;
    end
  end

  assign data_out    = dout_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_top_restoring_divider.sv
// Directed and random checks of top_restoring_divider against
// an arithmetic reference model.
module tb_top_restoring_divider;
  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [15:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  top_restoring_divider #(
    .DATA_WIDTH   (16),
    .OUTPUT_WIDTH (32)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .data_in     (data_in),
    .data_out    (data_out),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [15:0] a,
                                          input logic [15:0] b);
    if (b == 16'd0) return {a, 16'hFFFF};
    return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM in IDLE; drives one operation.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit stray, input int abort_at,
                        output int done_n, output int done_cnt,
                        output int busy_cnt, output logic [31:0] res,
                        output logic dbz);
    int n;
    done_n = -1;
    done_cnt = 0;
    busy_cnt = 0;
    res = 'x;
    dbz = 1'bx;
    start = 1'b1;
    data_in = a;
    @(negedge clk);
    start = 1'b0;
    data_in = b;
    n = 0;
    while (n <= 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) begin
          done_n = n;
          res = data_out;
          dbz = div_by_zero;
        end
      end
      if (n == abort_at) begin
        clear = 1'b1;
        #1;
        chk("abort_data_out", data_out, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_dbz", {31'h0, div_by_zero}, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        break;
      end
      if (done_n >= 0 && !busy) break;
      @(negedge clk);
      n++;
      start = stray && (n == 2 || n == 9);
      data_in = 16'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic div_check(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input bit stray);
    int dn, dc, bc;
    logic [31:0] r;
    logic z;
    run_op(a, b, stray, -1, dn, dc, bc, r, z);
    chk({tag, "_result"}, r, ref_div(a, b));
    chk({tag, "_dbz"}, {31'h0, z}, {31'h0, (b == 16'd0)});
    chk({tag, "_done_edge"}, 32'(dn), (b == 16'd0) ? 32'd1 : 32'd17);
    chk({tag, "_done_count"}, 32'(dc), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(bc), (b == 16'd0) ? 32'd2 : 32'd18);
  endtask

  initial begin
    int dn, dc, bc;
    logic [31:0] r;
    logic z;
    logic [15:0] ra, rb;
    clear = 1'b1;
    start = 1'b0;
    data_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_dbz", {31'h0, div_by_zero}, 32'h0);
    clear = 1'b0;
    @(negedge clk);

    div_check("d100_7", 16'd100, 16'd7, 1'b0);
    chk("d100_7_const", data_out, 32'h0002_000E);
    div_check("dffff_1", 16'hFFFF, 16'h0001, 1'b0);
    div_check("d3_10", 16'd3, 16'd10, 1'b0);
    chk("d3_10_const", data_out, 32'h0003_0000);
    div_check("d5_0", 16'd5, 16'd0, 1'b0);
    chk("d5_0_const", data_out, 32'h0005_FFFF);
    div_check("d9_2", 16'd9, 16'd2, 1'b0);
    div_check("stray", 16'h1234, 16'h0010, 1'b1);
    chk("stray_const", data_out, 32'h0004_0123);

    run_op(16'h5555, 16'h0003, 1'b0, 8, dn, dc, bc, r, z);
    chk("abort_no_done", 32'(dc), 32'd0);
    chk("abort_hold", data_out, 32'h0);
    div_check("dabcd_ff", 16'hABCD, 16'h00FF, 1'b0);
    div_check("d0_9", 16'd0, 16'd9, 1'b0);
    div_check("dffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(65535, 1));
      if (i < 5) rb = 16'($urandom_range(15, 1));
      div_check("rand", ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
